slavefifo2b_stream_out: RTL

SLAVEFIFO2B_STREAM_OUT -- requirements
Module: slavefifo2b_stream_out

---
 rtl/slavefifo2b_stream_out.sv | 137 +++++++++++++
 1 files changed

// File: rtl/slavefifo2b_stream_out.sv
// FX3 Slave FIFO (2-bit address) stream-out reader: pulls bursts from a consumer socket
// and checks the received words against an incrementing pattern.
module slavefifo2b_stream_out #(
    parameter logic [1:0] FADDR_OUT = 2'd3,
    parameter bit         CHECK_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset_in_,
    input  logic [31:0] fdata,
    output logic [1:0]  faddr,
    output logic        slrd,
    output logic        sloe,
    output logic        slwr,
    output logic        pktend,
    output logic        slcs,
    input  logic        flagc,
    input  logic        flagd,
    input  logic        enable,
    output logic [31:0] dout,
    output logic        dout_valid,
    output logic [31:0] word_count,
    output logic [15:0] err_count,
    output logic        err_flag
);

    typedef enum logic [2:0] {
        IDLE,
        FLAGC_RCVD,
        WAIT_FLAGD,
        READ,
        RD_OE_DELAY,
        OE_DELAY
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        flagc_d;
    logic        flagd_d;
    logic        oe_cnt;
    logic        oe_cnt_next;
    logic        rd_d1;
    logic        rd_d2;
    logic [31:0] expected;

    assign faddr  = FADDR_OUT;
    assign slwr   = 1'b1;
    assign pktend = 1'b1;
    assign slcs   = 1'b0;

    always_ff @(posedge clk or negedge reset_in_) begin
        if (!reset_in_) begin
            state   <= IDLE;
            flagc_d <= 1'b0;
            flagd_d <= 1'b0;
            oe_cnt  <= 1'b0;
        end else begin
            state   <= state_next;
            flagc_d <= flagc;
            flagd_d <= flagd;
            oe_cnt  <= oe_cnt_next;
        end
    end

    // sloe stays low for three cycles after the last strobe so in-flight data can land
    always_comb begin
        state_next  = state;
        oe_cnt_next = 1'b0;
        slrd        = 1'b1;
        sloe        = 1'b1;
        case (state)
            IDLE: begin
                if (enable && flagc_d) state_next = FLAGC_RCVD;
            end
            FLAGC_RCVD: begin
                state_next = WAIT_FLAGD;
            end
            WAIT_FLAGD: begin
                if (flagd_d) state_next = READ;
            end
            READ: begin
                slrd = 1'b0;
                sloe = 1'b0;
                if (!flagd_d) state_next = RD_OE_DELAY;
            end
            RD_OE_DELAY: begin
                sloe       = 1'b0;
                state_next = OE_DELAY;
            end
            OE_DELAY: begin
                sloe = 1'b0;
                if (oe_cnt) begin
                    state_next = IDLE;
                end else begin
                    oe_cnt_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FX3 returns data two cycles after the strobe; capture on the second delayed copy
    always_ff @(posedge clk or negedge reset_in_) begin
        if (!reset_in_) begin
            rd_d1      <= 1'b0;
            rd_d2      <= 1'b0;
            dout       <= 32'd0;
            dout_valid <= 1'b0;
            word_count <= 32'd0;
        end else begin
            rd_d1      <= ~slrd;
            rd_d2      <= rd_d1;
            dout_valid <= rd_d2;
            if (rd_d2) begin
                dout       <= fdata;
                word_count <= word_count + 32'd1;
            end
        end
    end

    // Resynchronising to captured+1 makes each discontinuity count only once
    always_ff @(posedge clk or negedge reset_in_) begin
        if (!reset_in_) begin
            expected  <= 32'd0;
            err_count <= 16'd0;
            err_flag  <= 1'b0;
        end else if (CHECK_EN && rd_d2) begin
            expected <= fdata + 32'd1;
            if (fdata != expected) begin
                err_flag <= 1'b1;
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
        end
    end

endmodule
